alu: RTL and testbench

- Parameterised unsigned ALU with a registered result and registered overflow/underflow flags.
- Operands A and B are combinationally evaluated according to a 4-bit opcode.
- The result is captured into the output registers only on a clock edge where the load strobe `set` is high; otherwise outputs hold.
- Used as a datapath leaf block; all arithmetic is unsigned and wraps modulo 2^WIDTH.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 53 +++++
 rtl/alu.sv | 52 +++++
 tb/tb_alu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding for the unsigned ALU and its combinational core.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_INC   = 4'd2,
      OP_DEC   = 4'd3,
      OP_CLR   = 4'd4,
      OP_AND   = 4'd5,
      OP_OR    = 4'd6,
      OP_XOR   = 4'd7,
      OP_NOT   = 4'd8,
      OP_NOR   = 4'd9,
      OP_SHL   = 4'd10,
      OP_SHR   = 4'd11,
      OP_ROL   = 4'd12,
      OP_ROR   = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU evaluation: opcode, A, B -> result plus carry/borrow flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  alu_op_e           opcode,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   output logic [WIDTH-1:0]  result,
   output logic              ovf,
   output logic              unf
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Extra bit captures the carry out of the MSB for ADD.
   logic [WIDTH:0] sum_ext;
   assign sum_ext = {1'b0, A} + {1'b0, B};

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      unf    = 1'b0;
      case (opcode)
         OP_ADD: {ovf, result} = sum_ext;
         OP_SUB: begin
            result = A - B;
            unf    = (A < B);
         end
         OP_INC: begin
            result = A + ONE;
            ovf    = &A;
         end
         OP_DEC: begin
            result = A - ONE;
            unf    = ~|A;
         end
         OP_CLR: result = '0;
         OP_AND: result = A & B;
         OP_OR:  result = A | B;
         OP_XOR: result = A ^ B;
         OP_NOT: result = ~A;
         OP_NOR: result = ~(A | B);
         OP_SHL: result = {A[WIDTH-2:0], 1'b0};
         OP_SHR: result = {1'b0, A[WIDTH-1:1]};
         OP_ROL: result = {A[WIDTH-2:0], A[WIDTH-1]};
         OP_ROR: result = {A[0], A[WIDTH-1:1]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Unsigned ALU with registered result and flags, loaded only while set is high.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        opcode,
   input  logic              set,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   output logic [WIDTH-1:0]  out,
   output logic              overflow,
   output logic              underflow
);

   logic [WIDTH-1:0] result_next;
   logic             ovf_next;
   logic             unf_next;

   logic [WIDTH-1:0] out_reg;
   logic             overflow_reg;
   logic             underflow_reg;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .opcode (alu_op_e'(opcode)),
      .A      (A),
      .B      (B),
      .result (result_next),
      .ovf    (ovf_next),
      .unf    (unf_next)
   );

   // Flags are rewritten on every load so they never stick across operations.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_reg       <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (set) begin
         out_reg       <= result_next;
         overflow_reg  <= ovf_next;
         underflow_reg <= unf_next;
      end
   end

   assign out       = out_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed table, randomized model comparison, hold and reset.
module tb_alu;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic          clk;
   logic          reset;
   logic [3:0]    opcode;
   logic          set;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [W-1:0]  out;
   logic          overflow;
   logic          underflow;

   int checks   = 0;
   int failures = 0;

   alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .set       (set),
      .A         (A),
      .B         (B),
      .out       (out),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic void model(input int op, input int a, input int b,
                                 output int r, output bit ov, output bit un);
      int mask;
      mask = MOD - 1;
      r  = 0;
      ov = 0;
      un = 0;
      case (op)
         0: begin r = (a + b) % MOD; ov = (a + b) >= MOD; end
         1: begin r = (a - b + MOD) % MOD; un = (a < b); end
         2: begin r = (a + 1) % MOD; ov = (a == mask); end
         3: begin r = (a + MOD - 1) % MOD; un = (a == 0); end
         4: r = 0;
         5: r = a & b;
         6: r = a | b;
         7: r = a ^ b;
         8: r = mask - a;
         9: r = mask - (a | b);
         10: r = (a * 2) % MOD;
         11: r = a / 2;
         12: r = (a * 2) % MOD + a / (MOD / 2);
         13: r = a / 2 + (a % 2) * (MOD / 2);
         default: r = 0;
      endcase
   endfunction

   // Drive one load away from the edge, then sample 1 time unit after the edge.
   task automatic do_load(input int op, input int a, input int b);
      @(negedge clk);
      opcode = op[3:0];
      A      = a[W-1:0];
      B      = b[W-1:0];
      set    = 1'b1;
      @(posedge clk);
      #1;
      set = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      set    = 1'b0;
      opcode = 4'd0;
      A      = '0;
      B      = '0;
      #12;
      checks++;
      if (out !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state out=%0d ovf=%b unf=%b required 0/0/0", out, overflow, underflow);
      end
      @(negedge clk);
      reset = 1'b1;
      do_load(0, 5, 4);
      checks++;
      if (out !== 4'd9) begin
         failures++;
         $display("FAIL pre_reset_load out=%0d required 9", out);
      end
      // Assert reset mid-cycle while clk is still high: no edge in between.
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (out !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL async_reset out=%0d ovf=%b unf=%b required 0/0/0", out, overflow, underflow);
      end
      $display("reset: async clear out=%0d ovf=%b unf=%b", out, overflow, underflow);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Directed cases with hand-derived expected values, in an order that exercises stale flags.
   int dir_op [26] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 5, 5, 6, 7, 7, 8, 8, 9, 9,
                       10, 10, 11, 11, 12, 13, 14, 15};
   int dir_a  [26] = '{5, 15, 5, 5, 5, 15, 5, 0, 10, 15, 12, 12, 12, 1, 0, 15, 15, 8,
                       8, 1, 8, 1, 11, 11, 7, 15};
   int dir_b  [26] = '{4, 4, 5, 6, 9, 9, 9, 9, 9, 15, 3, 3, 3, 0, 9, 9, 0, 4,
                       9, 9, 9, 9, 9, 9, 9, 15};
   int dir_r  [26] = '{9, 3, 0, 15, 6, 0, 4, 15, 0, 15, 0, 15, 15, 1, 15, 0, 0, 3,
                       0, 2, 4, 0, 7, 13, 0, 0};
   bit dir_ov [26] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0};
   bit dir_un [26] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0};

   task automatic test_directed();
      for (int i = 0; i < 26; i++) begin
         do_load(dir_op[i], dir_a[i], dir_b[i]);
         $display("directed[%0d]: op=%0d A=%0d B=%0d -> out=%0d ovf=%b unf=%b",
                  i, dir_op[i], dir_a[i], dir_b[i], out, overflow, underflow);
         checks++;
         if (out !== dir_r[i][W-1:0]) begin
            failures++;
            $display("FAIL directed_out[%0d] op=%0d got=%0d required=%0d", i, dir_op[i], out, dir_r[i]);
         end
         checks++;
         if (overflow !== dir_ov[i]) begin
            failures++;
            $display("FAIL directed_ovf[%0d] op=%0d got=%b required=%b", i, dir_op[i], overflow, dir_ov[i]);
         end
         checks++;
         if (underflow !== dir_un[i]) begin
            failures++;
            $display("FAIL directed_unf[%0d] op=%0d got=%b required=%b", i, dir_op[i], underflow, dir_un[i]);
         end
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] held_out;
      logic         held_ov;
      logic         held_un;
      do_load(0, 15, 4);
      held_out = out;
      held_ov  = overflow;
      held_un  = underflow;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         opcode = 4'($urandom_range(0, 15));
         A      = W'($urandom);
         B      = W'($urandom);
         @(posedge clk);
         #1;
         $display("hold[%0d]: op=%0d A=%0d B=%0d -> out=%0d ovf=%b unf=%b",
                  i, opcode, A, B, out, overflow, underflow);
         checks++;
         if (out !== held_out || overflow !== held_ov || underflow !== held_un) begin
            failures++;
            $display("FAIL hold[%0d] out=%0d ovf=%b unf=%b required %0d/%b/%b",
                     i, out, overflow, underflow, held_out, held_ov, held_un);
         end
      end
   endtask

   task automatic test_random();
      int r;
      bit ov;
      bit un;
      for (int i = 0; i < 150; i++) begin
         int op, a, b;
         op = $urandom_range(0, 15);
         a  = $urandom_range(0, MOD - 1);
         b  = $urandom_range(0, MOD - 1);
         model(op, a, b, r, ov, un);
         do_load(op, a, b);
         $display("random[%0d]: op=%0d A=%0d B=%0d -> out=%0d ovf=%b unf=%b",
                  i, op, a, b, out, overflow, underflow);
         checks++;
         if (out !== r[W-1:0] || overflow !== ov || underflow !== un) begin
            failures++;
            $display("FAIL random[%0d] op=%0d A=%0d B=%0d got=%0d/%b/%b required=%0d/%b/%b",
                     i, op, a, b, out, overflow, underflow, r, ov, un);
         end
      end
   endtask

   // set held high continuously; outputs must follow each cycle's inputs.
   task automatic test_back_to_back();
      int r;
      bit ov;
      bit un;
      @(negedge clk);
      set = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int op, a, b;
         op = $urandom_range(0, 3);
         a  = $urandom_range(0, MOD - 1);
         b  = $urandom_range(0, MOD - 1);
         opcode = op[3:0];
         A      = a[W-1:0];
         B      = b[W-1:0];
         model(op, a, b, r, ov, un);
         @(posedge clk);
         #1;
         $display("b2b[%0d]: op=%0d A=%0d B=%0d -> out=%0d ovf=%b unf=%b",
                  i, op, a, b, out, overflow, underflow);
         checks++;
         if (out !== r[W-1:0] || overflow !== ov || underflow !== un) begin
            failures++;
            $display("FAIL b2b[%0d] op=%0d A=%0d B=%0d got=%0d/%b/%b required=%0d/%b/%b",
                     i, op, a, b, out, overflow, underflow, r, ov, un);
         end
         @(negedge clk);
      end
      set = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
